gas_event_detect: RTL and testbench
===================================

GAS_EVENT_DETECT -- requirements
Module: gas_event_detect

Interface
REQ-001 Parameter N_CH, default 4: number of independent sensor channels, 1..16.
REQ-002 Parameter SYNC_STG, default 3: synchroniser depth, 2..4.
REQ-003 Parameter DB_CYC, default 1000: debounce stability window in clocks, 1..65535 (20 us at 50 MHz).
REQ-004 Parameter GAP_CYC, default 50000: idle hold-off between voice requests in clocks, 1..2^20-1.
REQ-005 Port clk_50M, in, 1: system clock, 50 MHz, all logic on the rising edge.
REQ-006 Port s_rst_n, in, 1: reset, asynchronous, active-low.
REQ-007 Port det_in, in, N_CH: raw asynchronous sensor DO lines, one per channel.
REQ-008 Port edge_mode, in, 2*N_CH: per-channel mode in bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 Port flag_clr, in, N_CH: per-channel single-cycle clear of alarm_flag.
REQ-010 Port voice_ack, in, 1: single-cycle acknowledge from the voice player.
REQ-011 Port det_level, out, N_CH: debounced level per channel.
REQ-012 Port edge_pulse, out, N_CH: single-cycle qualified edge event per channel.
REQ-013 Port alarm_flag, out, N_CH: sticky per-channel alarm.
REQ-014 Port voice_req, out, 1: voice playback request.
REQ-015 Port voice_ch, out, CH_W = max(1, clog2(N_CH)): channel index being announced.

Function
REQ-016 Each det_in bit SHALL pass through a SYNC_STG-deep flop chain; sync output = last stage.
REQ-017 Per channel, a 16-bit counter SHALL clear whenever sync output equals det_level, else increment; when it reaches DB_CYC-1 while still mismatched, det_level SHALL take the sync value on the next edge and the counter SHALL clear.
REQ-018 A mismatch shorter than DB_CYC consecutive cycles SHALL NOT change det_level; DB_CYC=1 SHALL update det_level one cycle after the sync output changes.
REQ-019 Latency: stable raw change to det_level change SHALL be SYNC_STG+DB_CYC cycles (+/-1 cycle for async sampling).
REQ-020 edge_pulse[i] SHALL be high for exactly one cycle, the cycle after det_level[i] changes, only if the direction is enabled by edge_mode[i]; mode 00 SHALL never pulse.
REQ-021 edge_mode changes SHALL take effect on the next det_level transition only; no pulse SHALL be generated by a mode change itself.
REQ-022 alarm_flag[i] SHALL set the cycle after edge_pulse[i] and clear the cycle after flag_clr[i]; simultaneous set and clear SHALL leave it set.
REQ-023 A pending[i] bit SHALL set with alarm_flag[i] set conditions and clear only on acknowledge of channel i; repeated edges while pending SHALL NOT queue further requests.
REQ-024 Voice FSM states: IDLE, REQ, GAP.
REQ-025 IDLE: if any pending bit set, latch voice_ch = lowest-index pending channel, assert voice_req, go REQ.
REQ-026 REQ: voice_req and voice_ch SHALL stay constant until voice_ack; on voice_ack clear pending[voice_ch], deassert voice_req next cycle, load gap counter, go GAP.
REQ-027 GAP: count GAP_CYC cycles with voice_req low, then IDLE; new edges during GAP SHALL still set pending.
REQ-028 An edge on channel voice_ch coinciding with voice_ack SHALL leave pending[voice_ch] set (set wins), producing a later re-announcement.
REQ-029 voice_ack in IDLE or GAP SHALL be ignored.
REQ-030 flag_clr SHALL NOT affect pending or the FSM.

Reset
REQ-031 On s_rst_n low: sync chains, det_level, counters, edge_pulse, alarm_flag, pending, voice_req, voice_ch SHALL be 0 and FSM SHALL be IDLE, immediately and asynchronously.
REQ-032 A channel held high through reset release SHALL produce a rising-edge event after SYNC_STG+DB_CYC cycles.
REQ-033 Reset asserted mid-REQ SHALL drop voice_req at once and discard all pending requests.

Verification (N_CH=4, SYNC_STG=3, DB_CYC=8, GAP_CYC=4)
REQ-034 ch0 mode 10, det_in[0] 1 held 20 cycles then 0 held -> det_level[0] rises ~11 cycles after; no pulse; fall gives edge_pulse[0] one cycle, alarm_flag[0]=1, voice_req=1, voice_ch=0.
REQ-035 ch1 mode 11, det_in[1] glitch high 5 cycles -> det_level, edge_pulse, alarm_flag unchanged.
REQ-036 ch2 and ch3 edges same cycle -> voice_ch=2 until ack, 4-cycle gap, then voice_ch=3.
REQ-037 flag_clr[0] same cycle as new edge_pulse[0] -> alarm_flag[0] stays 1; flag_clr alone next -> 0.
REQ-038 s_rst_n low while voice_req=1 -> all outputs 0 within the reset cycle; no request after release with inputs 0.

Source files
------------

// File: rtl/gas_event_detect.sv
// gas_event_detect: debounced multi-channel gas sensor edge detector with sticky alarms and a voice request arbiter.
module gas_event_detect #(
    parameter int N_CH     = 4,
    parameter int SYNC_STG = 3,
    parameter int DB_CYC   = 1000,
    parameter int GAP_CYC  = 50000,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_50M,
    input  logic              s_rst_n,
    input  logic [N_CH-1:0]   det_in,
    input  logic [2*N_CH-1:0] edge_mode,
    input  logic [N_CH-1:0]   flag_clr,
    input  logic              voice_ack,
    output logic [N_CH-1:0]   det_level,
    output logic [N_CH-1:0]   edge_pulse,
    output logic [N_CH-1:0]   alarm_flag,
    output logic              voice_req,
    output logic [CH_W-1:0]   voice_ch
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t            state, state_nxt;
    logic [N_CH-1:0]   det_prev, pending, ack_clr, pulse_nxt;
    logic [CH_W-1:0]   ch_nxt, lowest;
    logic [19:0]       gap_cnt, gap_nxt;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STG-1:0] sync_q;
        logic [15:0]         db_cnt;
        logic                lvl;
        always_ff @(posedge clk_50M or negedge s_rst_n) begin
            if (!s_rst_n) begin
                sync_q <= '0;
                db_cnt <= '0;
                lvl    <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STG-2:0], det_in[i]};
                if (sync_q[SYNC_STG-1] == lvl)
                    db_cnt <= '0;
                else if (db_cnt == 16'(DB_CYC - 1)) begin
                    lvl    <= sync_q[SYNC_STG-1];
                    db_cnt <= '0;
                end else
                    db_cnt <= db_cnt + 16'd1;
            end
        end
        assign det_level[i] = lvl;
        // mode is sampled at the transition, so a mode change alone never pulses
        assign pulse_nxt[i] = (lvl & ~det_prev[i] & edge_mode[2*i]) |
                              (~lvl & det_prev[i] & edge_mode[2*i+1]);
    end
    always_comb begin
        state_nxt = state;
        ch_nxt    = voice_ch;
        gap_nxt   = gap_cnt;
        ack_clr   = '0;
        lowest    = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (pending[k]) lowest = CH_W'(k);
        case (state)
            IDLE: if (|pending) begin
                state_nxt = REQ;
                ch_nxt    = lowest;
            end
            REQ: if (voice_ack) begin
                state_nxt = GAP;
                gap_nxt   = 20'(GAP_CYC - 1);
                ack_clr   = N_CH'(1) << voice_ch;
            end
            GAP: begin
                state_nxt = (gap_cnt == 20'd0) ? IDLE : GAP;
                gap_nxt   = (gap_cnt == 20'd0) ? gap_cnt : gap_cnt - 20'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_50M or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= IDLE;
            voice_ch   <= '0;
            gap_cnt    <= '0;
            det_prev   <= '0;
            edge_pulse <= '0;
            alarm_flag <= '0;
            pending    <= '0;
        end else begin
            state      <= state_nxt;
            voice_ch   <= ch_nxt;
            gap_cnt    <= gap_nxt;
            det_prev   <= det_level;
            edge_pulse <= pulse_nxt;
            // set wins over both flag_clr and acknowledge
            alarm_flag <= (alarm_flag & ~flag_clr) | edge_pulse;
            pending    <= (pending & ~ack_clr) | edge_pulse;
        end
    end
    assign voice_req = (state == REQ);
endmodule

// File: tb/tb_gas_event_detect.sv
// tb_gas_event_detect: directed scenario bench for gas_event_detect (N_CH=4, SYNC_STG=3, DB_CYC=8, GAP_CYC=4).
module tb_gas_event_detect;
    logic       clk_50M = 1'b0;
    logic       s_rst_n = 1'b0;
    logic [3:0] det_in = '0;
    logic [7:0] edge_mode = '0;
    logic [3:0] flag_clr = '0;
    logic       voice_ack = 1'b0;
    logic [3:0] det_level, edge_pulse, alarm_flag;
    logic       voice_req;
    logic [1:0] voice_ch;
    int pass_cnt = 0;
    int total_cnt = 0;

    gas_event_detect #(.N_CH(4), .SYNC_STG(3), .DB_CYC(8), .GAP_CYC(4)) dut (
        .clk_50M(clk_50M), .s_rst_n(s_rst_n), .det_in(det_in), .edge_mode(edge_mode),
        .flag_clr(flag_clr), .voice_ack(voice_ack), .det_level(det_level),
        .edge_pulse(edge_pulse), .alarm_flag(alarm_flag), .voice_req(voice_req), .voice_ch(voice_ch)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic test_reset;
        s_rst_n = 1'b0;
        edge_mode = 8'b11_11_11_10;
        tick(3);
        total_cnt++;
        if ({det_level, edge_pulse, alarm_flag, voice_req, voice_ch} !== 15'd0)
            $display("FAIL reset_outputs: got %h expected 0", {det_level, edge_pulse, alarm_flag, voice_req, voice_ch});
        else pass_cnt++;
        s_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_fall_mode;
        logic seen;
        det_in[0] = 1'b1;
        tick(10);
        total_cnt++;
        if (det_level[0] !== 1'b0) $display("FAIL rise_early: got %b expected 0", det_level[0]);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (det_level[0] !== 1'b1) $display("FAIL rise_latency: got %b expected 1", det_level[0]);
        else pass_cnt++;
        seen = 1'b0;
        repeat (9) begin
            tick(1);
            seen |= edge_pulse[0] | voice_req;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL fall_mode_no_rise_pulse: got %b expected 0", seen);
        else pass_cnt++;
        det_in[0] = 1'b0;
        tick(11);
        total_cnt++;
        if (det_level[0] !== 1'b0) $display("FAIL fall_latency: got %b expected 0", det_level[0]);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (edge_pulse !== 4'b0001) $display("FAIL fall_pulse: got %b expected 0001", edge_pulse);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({edge_pulse, alarm_flag, voice_req} !== {4'b0000, 4'b0001, 1'b0})
            $display("FAIL pulse_width_alarm: got %b expected 000000010", {edge_pulse, alarm_flag, voice_req});
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({voice_req, voice_ch} !== 3'b100) $display("FAIL req_ch0: got %b expected 100", {voice_req, voice_ch});
        else pass_cnt++;
        tick(3);
        voice_ack = 1'b1;
        tick(1);
        voice_ack = 1'b0;
        total_cnt++;
        if (voice_req !== 1'b0) $display("FAIL ack_drop: got %b expected 0", voice_req);
        else pass_cnt++;
        seen = 1'b0;
        repeat (10) begin
            tick(1);
            seen |= voice_req;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL no_reannounce: got %b expected 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        logic [3:0] seen;
        seen = '0;
        det_in[1] = 1'b1;
        repeat (5) begin
            tick(1);
            seen |= edge_pulse;
        end
        det_in[1] = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= edge_pulse;
        end
        total_cnt++;
        if ({seen, det_level[1], alarm_flag} !== {4'b0000, 1'b0, 4'b0001})
            $display("FAIL glitch_reject: got %b expected 000000001", {seen, det_level[1], alarm_flag});
        else pass_cnt++;
    endtask

    task automatic test_two_channels;
        int n;
        det_in[3:2] = 2'b11;
        tick(11);
        total_cnt++;
        if (det_level !== 4'b1100) $display("FAIL dual_level: got %b expected 1100", det_level);
        else pass_cnt++;
        tick(3);
        total_cnt++;
        if ({voice_req, voice_ch, alarm_flag} !== {1'b1, 2'd2, 4'b1101})
            $display("FAIL dual_first_ch2: got %b expected 1101101", {voice_req, voice_ch, alarm_flag});
        else pass_cnt++;
        tick(4);
        total_cnt++;
        if ({voice_req, voice_ch} !== {1'b1, 2'd2}) $display("FAIL ch2_hold: got %b expected 110", {voice_req, voice_ch});
        else pass_cnt++;
        voice_ack = 1'b1;
        tick(1);
        voice_ack = 1'b0;
        n = 0;
        while (!voice_req && n < 20) begin
            tick(1);
            n++;
        end
        total_cnt++;
        if (n !== 5) $display("FAIL gap_length: got %0d cycles expected 5", n);
        else pass_cnt++;
        total_cnt++;
        if ({voice_req, voice_ch} !== {1'b1, 2'd3}) $display("FAIL second_ch3: got %b expected 111", {voice_req, voice_ch});
        else pass_cnt++;
        voice_ack = 1'b1;
        tick(1);
        voice_ack = 1'b0;
        tick(10);
    endtask

    task automatic test_clr_collision;
        int n;
        flag_clr[0] = 1'b1;
        tick(1);
        flag_clr[0] = 1'b0;
        total_cnt++;
        if (alarm_flag !== 4'b1100) $display("FAIL clr_alone: got %b expected 1100", alarm_flag);
        else pass_cnt++;
        det_in[0] = 1'b1;
        tick(20);
        det_in[0] = 1'b0;
        tick(12);
        total_cnt++;
        if (edge_pulse[0] !== 1'b1) $display("FAIL second_fall_pulse: got %b expected 1", edge_pulse[0]);
        else pass_cnt++;
        flag_clr[0] = 1'b1;
        tick(1);
        total_cnt++;
        if (alarm_flag[0] !== 1'b1) $display("FAIL set_wins: got %b expected 1", alarm_flag[0]);
        else pass_cnt++;
        tick(1);
        flag_clr[0] = 1'b0;
        total_cnt++;
        if (alarm_flag[0] !== 1'b0) $display("FAIL clr_after_set: got %b expected 0", alarm_flag[0]);
        else pass_cnt++;
        n = 0;
        while (!voice_req && n < 20) begin
            tick(1);
            n++;
        end
        total_cnt++;
        if ({voice_req, voice_ch} !== {1'b1, 2'd0}) $display("FAIL clr_keeps_pending: got %b expected 100", {voice_req, voice_ch});
        else pass_cnt++;
        voice_ack = 1'b1;
        tick(1);
        voice_ack = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid_req;
        int n;
        det_in[1] = 1'b1;
        n = 0;
        while (!voice_req && n < 30) begin
            tick(1);
            n++;
        end
        total_cnt++;
        if ({voice_req, voice_ch} !== {1'b1, 2'd1}) $display("FAIL req_ch1: got %b expected 101", {voice_req, voice_ch});
        else pass_cnt++;
        #3;
        s_rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({det_level, edge_pulse, alarm_flag, voice_req, voice_ch} !== 15'd0)
            $display("FAIL async_reset: got %h expected 0", {det_level, edge_pulse, alarm_flag, voice_req, voice_ch});
        else pass_cnt++;
        det_in = '0;
        tick(2);
        s_rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            tick(1);
            n += voice_req + (alarm_flag != 0);
        end
        total_cnt++;
        if (n !== 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", n);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fall_mode();
        test_glitch();
        test_two_channels();
        test_clr_collision();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
